// File: rtl/alu_debug_console.sv
// Pushbutton/switch console that loads ALU operands and opcode, captures the result and shows it on hex digits.
// Optional macro ALU_DEBUG_SEXT_EN: sign-extend switch operands instead of zero-extending them.
module alu_debug_console #(
    parameter int WORD_W       = 32,
    parameter int SW_W         = 17,
    parameter int NDIGITS      = 5,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [3:0]             key,
    input  logic [SW_W-1:0]        sw,
    output logic [WORD_W-1:0]      alu_a,
    output logic [WORD_W-1:0]      alu_b,
    output logic [3:0]             aluop,
    input  logic [WORD_W-1:0]      alu_out,
    input  logic [2:0]             alu_flags,
    output logic [7*NDIGITS-1:0]   hex,
    output logic [2:0]             ledr,
    output logic [3:0]             ledg
);

    // state   | meaning
    // LOAD_A  | live sw shown, enter captures operand A
    // LOAD_B  | live sw shown, enter captures operand B
    // LOAD_OP | sw[3:0] shown, enter captures opcode
    // EXEC    | one cycle, result/flags latched on exit
    // SHOW    | selected register shown, flags on ledr
    localparam logic [2:0] S_LOAD_A  = 3'd0;
    localparam logic [2:0] S_LOAD_B  = 3'd1;
    localparam logic [2:0] S_LOAD_OP = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_SHOW    = 3'd4;

    localparam logic [1:0] SEL_RESULT = 2'd0;
    localparam logic [1:0] SEL_A      = 2'd1;
    localparam logic [1:0] SEL_B      = 2'd2;

    localparam int DISP_W = 4 * NDIGITS;
    localparam int CNT_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYC - 1);

    logic [2:0]        state;
    logic [WORD_W-1:0] a_reg, b_reg, res_reg;
    logic [3:0]        op_reg;
    logic [2:0]        flags_reg;
    logic [1:0]        sel;
    logic [WORD_W-1:0] sw_ext;
    logic [3:0]        key_raw, key_down, press;
    logic [CNT_W-1:0]  db_cnt [4];
    logic              do_clear, do_enter, do_back, do_view;
    logic [DISP_W-1:0] disp_val;

`ifdef ALU_DEBUG_SEXT_EN
    assign sw_ext = WORD_W'($signed(sw));
`else
    assign sw_ext = WORD_W'(sw);
`endif

    assign key_raw = ~key;

    // Down-counter per key reloads whenever the raw level agrees with the debounced level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            key_down <= 4'b0000;
            press    <= 4'b0000;
            for (int i = 0; i < 4; i++) db_cnt[i] <= CNT_LOAD;
        end else begin
            for (int i = 0; i < 4; i++) begin
                press[i] <= 1'b0;
                if (key_raw[i] != key_down[i]) begin
                    if (db_cnt[i] == '0) begin
                        key_down[i] <= key_raw[i];
                        db_cnt[i]   <= CNT_LOAD;
                        press[i]    <= key_raw[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] - 1'b1;
                    end
                end else begin
                    db_cnt[i] <= CNT_LOAD;
                end
            end
        end
    end

    assign do_clear = press[3];
    assign do_enter = press[0] & ~press[3];
    assign do_back  = press[1] & ~press[3] & ~press[0];
    assign do_view  = press[2] & ~press[3] & ~press[0] & ~press[1];

    always_ff @(posedge CLK) begin
        if (RST || do_clear) begin
            state     <= S_LOAD_A;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            op_reg    <= 4'h0;
            flags_reg <= 3'b000;
            sel       <= SEL_RESULT;
        end else begin
            case (state)
                S_LOAD_A: if (do_enter) begin
                    a_reg <= sw_ext;
                    state <= S_LOAD_B;
                end
                S_LOAD_B: if (do_enter) begin
                    b_reg <= sw_ext;
                    state <= S_LOAD_OP;
                end else if (do_back) begin
                    state <= S_LOAD_A;
                end
                S_LOAD_OP: if (do_enter) begin
                    op_reg <= sw[3:0];
                    state  <= S_EXEC;
                end else if (do_back) begin
                    state <= S_LOAD_B;
                end
                S_EXEC: begin
                    res_reg   <= alu_out;
                    flags_reg <= alu_flags;
                    state     <= S_SHOW;
                end
                S_SHOW: if (do_enter) begin
                    state <= S_LOAD_A;
                end else if (do_back) begin
                    state <= S_LOAD_OP;
                end else if (do_view) begin
                    case (sel)
                        SEL_RESULT: sel <= SEL_A;
                        SEL_A:      sel <= SEL_B;
                        default:    sel <= SEL_RESULT;
                    endcase
                end
                default: state <= S_LOAD_A;
            endcase
        end
    end

    assign alu_a = a_reg;
    assign alu_b = b_reg;
    assign aluop = op_reg;

    always_comb begin
        disp_val = '0;
        case (state)
            S_LOAD_A, S_LOAD_B: disp_val = DISP_W'(sw_ext);
            S_LOAD_OP:          disp_val = DISP_W'(sw[3:0]);
            S_EXEC:             disp_val = DISP_W'(res_reg);
            S_SHOW: begin
                case (sel)
                    SEL_A:   disp_val = DISP_W'(a_reg);
                    SEL_B:   disp_val = DISP_W'(b_reg);
                    default: disp_val = DISP_W'(res_reg);
                endcase
            end
            default:            disp_val = '0;
        endcase
    end

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h27;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
        assign hex[7*g +: 7] = seg7(disp_val[4*g +: 4]);
    end

    assign ledr = (state == S_SHOW) ? flags_reg : 3'b000;

    always_comb begin
        ledg = 4'b0001;
        case (state)
            S_LOAD_B:       ledg = 4'b0010;
            S_LOAD_OP:      ledg = 4'b0100;
            S_EXEC, S_SHOW: ledg = 4'b1000;
            default:        ledg = 4'b0001;
        endcase
    end

endmodule

// File: tb/tb_alu_debug_console.sv
// Directed plus randomized key/switch sequences for alu_debug_console, checked against a console-level model.
module tb_alu_debug_console;
    localparam int WW  = 32;
    localparam int SWW = 17;
    localparam int ND  = 5;
    localparam int DB  = 4;

    logic            CLK = 1'b0;
    logic            RST;
    logic [3:0]      key;
    logic [SWW-1:0]  sw;
    logic [WW-1:0]   alu_a, alu_b, alu_out;
    logic [3:0]      aluop;
    logic [2:0]      alu_flags;
    logic [7*ND-1:0] hex;
    logic [2:0]      ledr;
    logic [3:0]      ledg;

    int total = 0;
    int bad   = 0;

    alu_debug_console #(.WORD_W(WW), .SW_W(SWW), .NDIGITS(ND), .DEBOUNCE_CYC(DB)) dut (
        .CLK(CLK), .RST(RST), .key(key), .sw(sw),
        .alu_a(alu_a), .alu_b(alu_b), .aluop(aluop),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .hex(hex), .ledr(ledr), .ledg(ledg)
    );

    always #5 CLK = ~CLK;

    // ALU stand-in: 0 add, 1 sub, 2 and, 3 or, 4 xor, others pass A. Returns {neg, ovf, zero, result}.
    function automatic logic [34:0] alu_calc(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [31:0] r;
        logic ovf;
        ovf = 1'b0;
        case (op)
            4'd0: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            default: r = a;
        endcase
        return {r[31], ovf, (r == 32'd0), r};
    endfunction

    always_comb {alu_flags, alu_out} = alu_calc(alu_a, alu_b, aluop);

    // Model: 0 LOAD_A, 1 LOAD_B, 2 LOAD_OP, 3 SHOW (EXEC is never observed between presses)
    int          m_st;
    int          m_sel;
    logic [31:0] m_a, m_b, m_res;
    logic [3:0]  m_op;
    logic [2:0]  m_fl;
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

    function automatic logic [31:0] ext(input logic [SWW-1:0] s);
`ifdef ALU_DEBUG_SEXT_EN
        return s[SWW-1] ? (32'hFFFF_FFFF << SWW) | 32'(s) : 32'(s);
`else
        return 32'(s);
`endif
    endfunction

    function automatic logic [7*ND-1:0] hex_of(input logic [31:0] v);
        logic [7*ND-1:0] h;
        h = '0;
        for (int d = 0; d < ND; d++) h[7*d +: 7] = seg_tab[(v >> (4*d)) & 32'hF];
        return h;
    endfunction

    function automatic logic [31:0] model_disp();
        case (m_st)
            0, 1: return ext(sw);
            2:    return 32'(sw[3:0]);
            default: return (m_sel == 0) ? m_res : (m_sel == 1) ? m_a : m_b;
        endcase
    endfunction

    task automatic model_reset();
        m_st = 0; m_sel = 0; m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_fl = 0;
    endtask

    task automatic model_press(input logic [3:0] mask);
        logic [34:0] r;
        if (mask[3]) model_reset();
        else if (mask[0]) begin
            case (m_st)
                0: begin m_a = ext(sw); m_st = 1; end
                1: begin m_b = ext(sw); m_st = 2; end
                2: begin
                    m_op = sw[3:0];
                    r = alu_calc(m_a, m_b, m_op);
                    m_res = r[31:0]; m_fl = r[34:32]; m_st = 3;
                end
                default: m_st = 0;
            endcase
        end else if (mask[1]) begin
            if (m_st == 1) m_st = 0;
            else if (m_st == 2) m_st = 1;
            else if (m_st == 3) m_st = 2;
        end else if (mask[2]) begin
            if (m_st == 3) m_sel = (m_sel + 1) % 3;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] eg;
        eg = 4'b0001 << m_st;
        check({tag, ".ledg"}, 64'(ledg), 64'(eg));
        check({tag, ".ledr"}, 64'(ledr), 64'((m_st == 3) ? m_fl : 3'b000));
        check({tag, ".alu_a"}, 64'(alu_a), 64'(m_a));
        check({tag, ".alu_b"}, 64'(alu_b), 64'(m_b));
        check({tag, ".aluop"}, 64'(aluop), 64'(m_op));
        check({tag, ".hex"}, 64'(hex), 64'(hex_of(model_disp())));
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        @(negedge CLK);
        key = ~mask;
        repeat (hold) @(negedge CLK);
        key = 4'hF;
        repeat (DB + 2) @(negedge CLK);
    endtask

    task automatic do_press(input logic [3:0] mask);
        press(mask, DB);
        model_press(mask);
    endtask

    initial begin
        logic [3:0] mask;
        int r;
        RST = 1'b1;
        key = 4'hF;
        sw  = 17'h1FFFF;
        repeat (3) @(negedge CLK);
        model_reset();
        check("rst.ledg", 64'(ledg), 64'(4'b0001));
        check("rst.alu_a", 64'(alu_a), 64'(32'd0));
        check("rst.ledr", 64'(ledr), 64'(3'b000));
`ifdef ALU_DEBUG_SEXT_EN
        check("rst.hex", 64'(hex), 64'({7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E}));
`else
        check("rst.hex", 64'(hex), 64'({7'h79, 7'h0E, 7'h0E, 7'h0E, 7'h0E}));
`endif
        RST = 1'b0;
        @(negedge CLK);
        check_all("after_rst");

        sw = 17'd5; do_press(4'b0001);
        sw = 17'd3; do_press(4'b0001);
        sw = 17'd0; do_press(4'b0001);
        check("add.ledg", 64'(ledg), 64'(4'b1000));
        check("add.hex", 64'(hex), 64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h00}));
        check("add.ledr", 64'(ledr), 64'(3'b000));
        check_all("add");

        // Short hold is ignored; a long hold advances exactly once.
        press(4'b0001, DB - 1);
        check("short_hold.ledg", 64'(ledg), 64'(4'b1000));
        @(negedge CLK);
        key = 4'b1110;
        repeat (3 * DB) @(negedge CLK);
        check("long_hold.ledg", 64'(ledg), 64'(4'b0001));
        key = 4'hF;
        repeat (DB + 2) @(negedge CLK);
        model_press(4'b0001);
        check_all("long_hold");

        sw = SWW'($urandom); do_press(4'b0001);
        check_all("to_load_b");
        sw = SWW'($urandom); do_press(4'b1001);
        check("enter_clear.ledg", 64'(ledg), 64'(4'b0001));
        check("enter_clear.alu_a", 64'(alu_a), 64'(32'd0));

        sw = SWW'($urandom); do_press(4'b0001);
        sw = SWW'($urandom); do_press(4'b0001);
        sw = SWW'($urandom_range(0, 5)); do_press(4'b0001);
        check_all("show_res");
        do_press(4'b0100);
        check("view1.hex", 64'(hex), 64'(hex_of(m_a)));
        do_press(4'b0100);
        check("view2.hex", 64'(hex), 64'(hex_of(m_b)));
        do_press(4'b0100);
        check("view3.hex", 64'(hex), 64'(hex_of(m_res)));
        do_press(4'b0010);
        check("back.ledg", 64'(ledg), 64'(4'b0100));
        check_all("back");

        do_press(4'b1000);
        sw = 17'h10000; do_press(4'b0001);
`ifdef ALU_DEBUG_SEXT_EN
        check("ext.alu_a", 64'(alu_a), 64'(32'hFFFF0000));
`else
        check("ext.alu_a", 64'(alu_a), 64'(32'h00010000));
`endif

        for (int it = 0; it < 60; it++) begin
            sw = SWW'($urandom);
            r = $urandom_range(0, 11);
            if (r < 5) mask = 4'b0001;
            else if (r < 7) mask = 4'b0010;
            else if (r < 9) mask = 4'b0100;
            else if (r == 9) mask = 4'b1000;
            else mask = 4'($urandom_range(1, 15));
            if (m_st == 2 && mask[0] && !mask[3]) sw[3:0] = 4'($urandom_range(0, 5));
            do_press(mask);
            check_all($sformatf("rand%0d", it));
        end

        // Reset while in EXEC must not latch the result.
        do_press(4'b1000);
        sw = 17'h00007; do_press(4'b0001);
        sw = 17'h00009; do_press(4'b0001);
        sw = 17'd0;
        @(negedge CLK);
        key = 4'b1110;
        repeat (DB) @(negedge CLK);
        @(negedge CLK);
        check("exec.ledg", 64'(ledg), 64'(4'b1000));
        RST = 1'b1;
        key = 4'hF;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        check_all("exec_rst");
        press(4'b0001, DB - 1);
        check_all("post_rst_short");
        do_press(4'b0001);
        do_press(4'b0001);
        do_press(4'b0010);
        do_press(4'b0001);
        do_press(4'b0001);
        check_all("post_rst_flow");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
